// File: rtl/mesh_input_port.sv
// ---------------------------------------------------------------------------
// mesh_input_port
//
// Input-port unit for one side (L, E, W, N, S) of a mesh NoC router.
// Incoming flits are buffered in a DEPTH-deep circular FIFO. A three-state
// FSM (IDLE -> ROUTE -> SEND) computes an XY-routing direction for the head
// flit, registers it, and presents the head flit to the switch.
//
// Parameters
//   WIDTH   flit width (>= 2*COORD_W+1)
//   DEPTH   FIFO entries (power of two, >= 2)
//   COORD_W bits per destination coordinate
//   MY_X    this router's X coordinate
//   MY_Y    this router's Y coordinate
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   Write     push request for in_flit
//   in_flit   incoming flit: [WIDTH-1]=valid, [2*COORD_W-1:COORD_W]=dest Y,
//             [COORD_W-1:0]=dest X
//   full      FIFO holds DEPTH flits (combinational from count)
//   Read      switch accepts out_flit this cycle
//   out_flit  head flit (mem[rd_ptr])
//   out_valid out_flit / out_dir valid (FSM in SEND)
//   out_dir   one-hot route: [0]=L [1]=E [2]=W [3]=N [4]=S
//   ovf_cnt   count of rejected pushes, saturating at 255
//
// Handshake: the port offers a flit while out_valid=1; a transfer happens
// on a rising edge where out_valid=1 and Read=1. Read while out_valid=0 has
// no effect. On the push side, a flit with its valid bit set is taken on a
// rising edge where Write=1 and full=0; otherwise it is dropped.
//
// Build option: define MESH_PORT_OVF_CNT_EN to build the overflow counter;
// without it ovf_cnt is a constant zero.
// ---------------------------------------------------------------------------
module mesh_input_port #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int COORD_W = 2,
    parameter int MY_X    = 0,
    parameter int MY_Y    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Write,
    input  logic [WIDTH-1:0] in_flit,
    output logic             full,
    input  logic             Read,
    output logic [WIDTH-1:0] out_flit,
    output logic             out_valid,
    output logic [4:0]       out_dir,
    output logic [7:0]       ovf_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0]      DEPTH_C = CW'(DEPTH);
    localparam logic [COORD_W-1:0] MY_X_C  = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C  = COORD_W'(MY_Y);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUTE = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;

    localparam logic [4:0] DIR_L = 5'b00001;
    localparam logic [4:0] DIR_E = 5'b00010;
    localparam logic [4:0] DIR_W = 5'b00100;
    localparam logic [4:0] DIR_N = 5'b01000;
    localparam logic [4:0] DIR_S = 5'b10000;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_nx;
    logic [1:0]         state;
    logic [1:0]         state_nx;
    logic [4:0]         dir_q;
    logic [4:0]         route;
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    logic               push;
    logic               pop;

    assign full      = (count == DEPTH_C);
    assign out_flit  = mem[rd_ptr];
    assign out_valid = (state == SEND);
    assign out_dir   = dir_q;

    // A push is decided on the count before the edge, so a pop in the same
    // cycle does not free a slot for a push arriving while full.
    assign push = Write && in_flit[WIDTH-1] && !full;
    assign pop  = (state == SEND) && Read;

    assign count_nx = count + CW'(push) - CW'(pop);

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_flit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nx;
        end
    end

    // ------------------------------------------------------------------
    // XY routing of the head flit: X is resolved before Y.
    // ------------------------------------------------------------------
    assign dest_x = out_flit[COORD_W-1:0];
    assign dest_y = out_flit[2*COORD_W-1:COORD_W];

    always_comb begin
        route = DIR_L;
        if (dest_x > MY_X_C) begin
            route = DIR_E;
        end else if (dest_x < MY_X_C) begin
            route = DIR_W;
        end else if (dest_y > MY_Y_C) begin
            route = DIR_S;
        end else if (dest_y < MY_Y_C) begin
            route = DIR_N;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM. ROUTE is a dedicated cycle so the direction is taken
    // from a settled head flit and held stable for all of SEND.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nx = ROUTE;
                end
            end
            ROUTE: begin
                state_nx = SEND;
            end
            SEND: begin
                if (Read) begin
                    state_nx = (count_nx != '0) ? ROUTE : IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            dir_q <= '0;
        end else begin
            state <= state_nx;
            if (state == ROUTE) begin
                dir_q <= route;
            end
        end
    end

    // ------------------------------------------------------------------
    // Overflow counter (optional)
    // ------------------------------------------------------------------
`ifdef MESH_PORT_OVF_CNT_EN
    logic       reject;
    logic [7:0] ovf_q;

    assign reject = Write && in_flit[WIDTH-1] && full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= '0;
        end else if (reject && (ovf_q != 8'hFF)) begin
            ovf_q <= ovf_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_q;
`else
    assign ovf_cnt = 8'h00;
`endif

endmodule
